// File: rtl/uart_alu_sequencer.sv
// Command sequencer between the UART and the ALU. It collects an opcode and two
// multi-byte operands, commits them to the ALU, and returns the result one byte at a time.
module uart_alu_sequencer #(
  parameter int NB_DATA        = 16,
  parameter int NB_OP          = 6,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic [7:0]         i_rx_data,
  input  logic               i_rx_done,
  input  logic [NB_DATA-1:0] i_alu_result,
  input  logic               i_tx_busy,
  output logic [NB_DATA-1:0] o_operand_a,
  output logic [NB_DATA-1:0] o_operand_b,
  output logic [NB_OP-1:0]   o_opcode,
  output logic [7:0]         o_tx_data,
  output logic               o_tx_start,
  output logic               o_busy,
  output logic               o_timeout,
  output logic               o_overrun
);

  localparam int NB_BYTES = NB_DATA / 8;
  localparam int CNT_W    = $clog2(NB_BYTES + 1);
  localparam int TMO_W    = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    IDLE, RX_A, RX_B, EXEC, CAPT, TX_SEND, TX_HOLD
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   byteCnt_q, byteCnt_d;
  logic [TMO_W-1:0]   tmoCnt_q, tmoCnt_d;
  logic [NB_DATA-1:0] shadowA_q, shadowA_d;
  logic [NB_DATA-1:0] shadowB_q, shadowB_d;
  logic [NB_OP-1:0]   shadowOp_q, shadowOp_d;
  logic [NB_DATA-1:0] opA_q, opA_d;
  logic [NB_DATA-1:0] opB_q, opB_d;
  logic [NB_OP-1:0]   opcode_q, opcode_d;
  logic [NB_DATA-1:0] result_q, result_d;
  logic [7:0]         txData_q, txData_d;
  logic               txStart_q, txStart_d;
  logic               busy_q, busy_d;
  logic               timeout_q, timeout_d;
  logic               overrun_q, overrun_d;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q    <= IDLE;
      byteCnt_q  <= '0;
      tmoCnt_q   <= '0;
      shadowA_q  <= '0;
      shadowB_q  <= '0;
      shadowOp_q <= '0;
      opA_q      <= '0;
      opB_q      <= '0;
      opcode_q   <= '0;
      result_q   <= '0;
      txData_q   <= '0;
      txStart_q  <= 1'b0;
      busy_q     <= 1'b0;
      timeout_q  <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      byteCnt_q  <= byteCnt_d;
      tmoCnt_q   <= tmoCnt_d;
      shadowA_q  <= shadowA_d;
      shadowB_q  <= shadowB_d;
      shadowOp_q <= shadowOp_d;
      opA_q      <= opA_d;
      opB_q      <= opB_d;
      opcode_q   <= opcode_d;
      result_q   <= result_d;
      txData_q   <= txData_d;
      txStart_q  <= txStart_d;
      busy_q     <= busy_d;
      timeout_q  <= timeout_d;
      overrun_q  <= overrun_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    byteCnt_d  = byteCnt_q;
    tmoCnt_d   = tmoCnt_q;
    shadowA_d  = shadowA_q;
    shadowB_d  = shadowB_q;
    shadowOp_d = shadowOp_q;
    opA_d      = opA_q;
    opB_d      = opB_q;
    opcode_d   = opcode_q;
    result_d   = result_q;
    txData_d   = txData_q;
    txStart_d  = 1'b0;
    timeout_d  = 1'b0;
    overrun_d  = 1'b0;

    case (state_q)
      IDLE: begin
        tmoCnt_d = '0;
        if (i_rx_done) begin
          shadowOp_d = i_rx_data[NB_OP-1:0];
          byteCnt_d  = '0;
          state_d    = RX_A;
        end
      end

      RX_A, RX_B: begin
        // A strobe in the expiry cycle still counts as a byte and restarts the timer.
        if (i_rx_done) begin
          tmoCnt_d = '0;
          for (int i = 0; i < NB_BYTES; i++) begin
            if (byteCnt_q == CNT_W'(i)) begin
              if (state_q == RX_A) shadowA_d[i*8 +: 8] = i_rx_data;
              else                 shadowB_d[i*8 +: 8] = i_rx_data;
            end
          end
          if (byteCnt_q == CNT_W'(NB_BYTES - 1)) begin
            byteCnt_d = '0;
            state_d   = (state_q == RX_A) ? RX_B : EXEC;
          end else begin
            byteCnt_d = byteCnt_q + CNT_W'(1);
          end
        end else if (tmoCnt_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
          timeout_d  = 1'b1;
          tmoCnt_d   = '0;
          byteCnt_d  = '0;
          shadowA_d  = '0;
          shadowB_d  = '0;
          shadowOp_d = '0;
          state_d    = IDLE;
        end else begin
          tmoCnt_d = tmoCnt_q + TMO_W'(1);
        end
      end

      EXEC: begin
        opA_d    = shadowA_q;
        opB_d    = shadowB_q;
        opcode_d = shadowOp_q;
        state_d  = CAPT;
      end

      CAPT: begin
        result_d  = i_alu_result;
        byteCnt_d = '0;
        state_d   = TX_SEND;
      end

      TX_SEND: begin
        if (!i_tx_busy) begin
          for (int i = 0; i < NB_BYTES; i++) begin
            if (byteCnt_q == CNT_W'(i)) txData_d = result_q[i*8 +: 8];
          end
          txStart_d = 1'b1;
          byteCnt_d = byteCnt_q + CNT_W'(1);
          state_d   = TX_HOLD;
        end
      end

      TX_HOLD: begin
        // Busy is not trusted here; the transmitter needs a cycle to raise it.
        if (byteCnt_q == CNT_W'(NB_BYTES)) begin
          byteCnt_d = '0;
          state_d   = IDLE;
        end else begin
          state_d = TX_SEND;
        end
      end

      default: state_d = IDLE;
    endcase

    overrun_d = i_rx_done && (state_q inside {EXEC, CAPT, TX_SEND, TX_HOLD});
    busy_d    = (state_d != IDLE);
  end

  assign o_operand_a = opA_q;
  assign o_operand_b = opB_q;
  assign o_opcode    = opcode_q;
  assign o_tx_data   = txData_q;
  assign o_tx_start  = txStart_q;
  assign o_busy      = busy_q;
  assign o_timeout   = timeout_q;
  assign o_overrun   = overrun_q;

endmodule
